// File: rtl/seg_adder_pkg.sv
// seg_adder_pkg: shared FSM state type and segment/counter sizing helpers for seg_adder
package seg_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int nseg_of(input int width, input int seg);
    return width / seg;
  endfunction
  function automatic int cnt_width(input int nseg);
    return nseg > 1 ? $clog2(nseg) : 1;
  endfunction
endpackage

// File: rtl/seg_add_slice.sv
// seg_add_slice: combinational SEG-bit ripple full-adder chain with carry into the MSB exposed
module seg_add_slice #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] x,
  input  logic [SEG-1:0] y,
  input  logic           ci,
  output logic [SEG-1:0] sum,
  output logic           co,
  output logic           cm
);
  logic c;
  always_comb begin
    c = ci;
    sum = '0;
    for (int i = 0; i < SEG; i++) begin
      sum[i] = x[i] ^ y[i] ^ c;
      c = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end
  assign cm = sum[SEG-1] ^ x[SEG-1] ^ y[SEG-1];
endmodule

// File: rtl/seg_adder.sv
// seg_adder: multi-cycle segmented WIDTH-bit adder, SEG bits per cycle; SEG_ADDER_SUB_EN adds the sub port
module seg_adder
  import seg_adder_pkg::*;
#(
  parameter int WIDTH = 40,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEG_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int NSEG = nseg_of(WIDTH, SEG);
  localparam int CW   = cnt_width(NSEG);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_r, b_r;
  logic [SEG-1:0] a_seg [NSEG];
  logic [SEG-1:0] b_seg [NSEG];
  logic [SEG-1:0] s_seg [NSEG];
  logic [SEG-1:0] sum;
  logic carry, co, cm, last, sub_i;
`ifdef SEG_ADDER_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif
  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    assign a_seg[g] = a_r[g*SEG +: SEG];
    assign b_seg[g] = b_r[g*SEG +: SEG];
    assign s[g*SEG +: SEG] = s_seg[g];
  end
  seg_add_slice #(.SEG(SEG)) u_slice (
    .x  (a_seg[cnt]),
    .y  (b_seg[cnt]),
    .ci (carry),
    .sum(sum),
    .co (co),
    .cm (cm)
  );
  assign last = cnt == CW'(NSEG - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = (state == IDLE) ? (in_valid ? RUN : IDLE) :
          (state == RUN)  ? (last ? DONE : RUN) :
          (out_ready ? IDLE : DONE);
  end
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
  end
  // Subtraction is a + ~b + 1: the inversion and forced carry are applied once at accept.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      carry <= 1'b0;
      cnt <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
      for (int i = 0; i < NSEG; i++) s_seg[i] <= '0;
    end else if (in_ready && in_valid) begin
      a_r <= a;
      b_r <= sub_i ? ~b : b;
      carry <= sub_i | cin;
      cnt <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
      for (int i = 0; i < NSEG; i++) s_seg[i] <= '0;
    end else if (state == RUN) begin
      s_seg[cnt] <= sum;
      carry <= co;
      cnt <= cnt + 1'b1;
      if (last) begin
        cout <= co;
        ovf <= cm ^ co;
      end
    end
endmodule
